// File: rtl/memory_reader.sv
// Sequential read-out engine: scans every entry of the byte store in address
// order, streams each byte on a valid/ready port and accumulates a mod-2**WIDTH checksum.
module memory_reader #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int WIDTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  checksum,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {IDLE, SET, SEND, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [WIDTH-1:0]  data_q, data_nx;
   logic              valid_q, valid_nx;
   logic [WIDTH-1:0]  sum_q, sum_nx;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         addr    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sum_q   <= '0;
      end else begin
         state   <= state_nx;
         addr    <= addr_nx;
         data_q  <= data_nx;
         valid_q <= valid_nx;
         sum_q   <= sum_nx;
      end
   end

   // Output stream: a byte transfers on any rising edge where out_valid and
   // out_ready are both 1; out_valid never falls before that edge, and
   // out_data stays frozen while out_valid is high and out_ready is low.
   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      data_nx  = data_q;
      valid_nx = valid_q;
      sum_nx   = sum_q;
      case (state)
         IDLE: begin
            addr_nx = '0;
            if (start) begin
               state_nx = SET;
               sum_nx   = '0;
            end
         end
         SET: begin
            // Address has been stable for a full cycle, so the read data is settled.
            data_nx  = mem_rdata;
            sum_nx   = sum_q + mem_rdata;
            valid_nx = 1'b1;
            state_nx = SEND;
         end
         SEND: begin
            if (out_ready) begin
               valid_nx = 1'b0;
               if (addr == LAST_ADDR) begin
                  state_nx = DONE;
               end else begin
                  addr_nx  = addr + 1'b1;
                  state_nx = SET;
               end
            end
         end
         DONE: begin
            addr_nx  = '0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            addr_nx  = '0;
            valid_nx = 1'b0;
         end
      endcase
   end

   assign mem_addr  = addr;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign checksum  = sum_q;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_memory_reader.sv
// Bench for memory_reader: a behavioural byte store feeds the DUT, and each scan
// is checked against the stored bytes, their modulo-256 sum and the cycle budget.
module tb_memory_reader;

   logic       clk;
   logic       reset;
   logic       start;
   logic [1:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic [7:0] checksum;
   logic [1:0] state_dbg;

   logic [7:0] store [4];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   memory_reader #(.DEPTH(4), .ADDR_W(2), .WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum),
      .state_dbg (state_dbg)
   );

   assign mem_rdata = store[mem_addr];

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_addr"},  mem_addr,  0);
      chk({tag, "_data"},  out_data,  0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"},  busy,      0);
      chk({tag, "_done"},  done,      0);
      chk({tag, "_sum"},   checksum,  0);
   endtask

   // One full scan. stall_len cycles of out_ready=0 are inserted on byte stall_idx;
   // poke_start re-pulses start during byte 1 and in the done cycle;
   // poke_mem rewrites store[1] while byte 1 is being presented.
   task automatic run_scan(input int stall_idx, input int stall_len,
                           input bit poke_start, input bit poke_mem);
      logic [7:0] exp_q[$];
      logic [7:0] exp_sum;
      int s, n, byte_idx, stalled, dones, first_valid;
      bit prev_hold, changed;
      exp_q = {};
      s = 0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(store[i]);
         s += int'(store[i]);
      end
      exp_sum = 8'(s % 256);

      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;      // E0 has just sampled start
      start = 1'b0;
      @(negedge clk);
      chk("busy_e0", busy, 1);
      chk("valid_e0", out_valid, 0);

      n = 0; byte_idx = 0; stalled = 0; dones = 0; first_valid = -1;
      prev_hold = 1'b0; changed = 1'b0;
      while (n < 80) begin
         @(posedge clk); #1;
         n++;
         start = 1'b0;
         if (poke_start && out_valid && byte_idx == 1) start = 1'b1;
         if (poke_start && done) start = 1'b1;
         if (poke_mem && out_valid && byte_idx == 1 && !changed) begin
            store[1] = ~store[1];
            changed = 1'b1;
         end
         if (out_valid && byte_idx == stall_idx && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         if (prev_hold) chk("valid_hold", out_valid, 1);
         if (out_valid) begin
            if (first_valid < 0) first_valid = n;
            if (byte_idx < 4) begin
               chk("data", out_data, exp_q[byte_idx]);
               chk("addr", mem_addr, byte_idx);
            end else begin
               chk("extra_byte", byte_idx, 3);
            end
            prev_hold = !out_ready;
            if (out_ready) byte_idx++;
         end else begin
            prev_hold = 1'b0;
         end
         if (done) begin
            dones++;
            chk("done_cycle", n, 8 + stall_len);
            chk("sum_at_done", checksum, exp_sum);
            chk("bytes_at_done", byte_idx, 4);
         end
         if (!busy) break;
      end
      start = 1'b0;
      chk("idle_cycle", n, 9 + stall_len);
      chk("first_valid", first_valid, 1);
      chk("done_count", dones, 1);
      chk("byte_count", byte_idx, 4);
      chk("sum_idle", checksum, exp_sum);
      if (poke_start) begin
         repeat (3) begin
            @(negedge clk);
            chk("no_restart", busy, 0);
         end
      end
   endtask

   task automatic reset_mid_scan();
      bit found;
      found = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (out_valid && mem_addr == 2) found = 1'b1;
      end
      chk("reach_byte2", found, 1);
      // Reset lands on the edge that would otherwise accept byte 2; start is also high.
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk_reset_values("rst_mid");
      reset = 1'b0;
      start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_done", done, 0);
         chk("rst_idle", busy, 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) store[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_values("por");
      reset = 1'b0;

      store[0] = 8'h11; store[1] = 8'h22; store[2] = 8'h33; store[3] = 8'h44;
      run_scan(-1, 0, 1'b0, 1'b0);
      run_scan(2, 5, 1'b0, 1'b0);

      store[0] = 8'hFF; store[1] = 8'hFF; store[2] = 8'h01; store[3] = 8'h02;
      run_scan(-1, 0, 1'b0, 1'b0);

      store[0] = 8'h11; store[1] = 8'h22; store[2] = 8'h33; store[3] = 8'h44;
      run_scan(-1, 0, 1'b1, 1'b0);
      store[0] = 8'h05; store[1] = 8'h06; store[2] = 8'h07; store[3] = 8'h08;
      run_scan(-1, 0, 1'b0, 1'b0);

      reset_mid_scan();
      run_scan(-1, 0, 1'b0, 1'b0);

      run_scan(-1, 0, 1'b0, 1'b1);
      chk("poked_store", store[1], 8'hF9);
      run_scan(-1, 0, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) store[i] = 8'($urandom);
         run_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
